// File: rtl/pc_sequencer.sv
// pc_sequencer -- next-PC controller for the fetch stage.
//
// Chooses the next fetch PC from the sequential path (+INSTR_BYTES), an
// EX-stage taken branch or an ID-stage jump. Holds the PC while the hazard
// unit stalls, remembers a redirect that shows up during a stall, issues a
// one-cycle IF/ID flush whenever a redirect is taken, and parks the core at
// HALT_PC until reset.
//
// Optional feature macro: PC_SEQ_PERF_CNT_EN
//   When defined, two saturating 16-bit performance counters are added:
//   stall_cnt_o (stalled cycles outside HALT) and redirect_cnt_o (flush pulses).
//
// Ports
//   clk_i            in   1     clock, all state on rising edge
//   start_i          in   1     synchronous active-low reset
//   stall_i          in   1     hazard stall, hold PC
//   branch_i         in   1     EX-stage taken branch
//   branch_target_i  in   XLEN  branch target
//   jump_i           in   1     ID-stage jump
//   jump_target_i    in   XLEN  jump target
//   pc_o             out  XLEN  registered fetch PC
//   flush_o          out  1     registered 1-cycle IF/ID flush pulse
//   halted_o         out  1     core parked at HALT_PC
//   state_o          out  2     00 RUN, 01 STALL, 10 HALT
//   stall_cnt_o      out  16    (macro only) stalled-cycle counter
//   redirect_cnt_o   out  16    (macro only) flush-pulse counter
module pc_sequencer #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [XLEN-1:0] HALT_PC     = 248,
  parameter logic [XLEN-1:0] INSTR_BYTES = 4
) (
  input  logic            clk_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            flush_o,
  output logic            halted_o,
  output logic [1:0]      state_o
`ifdef PC_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]     stall_cnt_o,
  output logic [15:0]     redirect_cnt_o
`endif
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  // Instruction fetch is word-granular, so the low two target bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_flush;
  logic            r_halted;
  logic            r_pend_v;
  logic [XLEN-1:0] r_pend_tgt;

  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_jmp_tgt;
  logic [XLEN-1:0] w_redir_tgt;
  logic            w_redirect;
  logic [XLEN-1:0] w_seq_pc;

  always_comb begin
    w_br_tgt    = word_align(branch_target_i);
    w_jmp_tgt   = word_align(jump_target_i);
    w_redirect  = branch_i | jump_i;
    // Branch is older than jump in program order, so it wins.
    w_redir_tgt = branch_i ? w_br_tgt : w_jmp_tgt;
    w_seq_pc    = r_pc + INSTR_BYTES;
  end

  // Stage p0: next-PC selection and FSM update
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_flush  <= 1'b0;
      r_halted <= 1'b0;
      r_pend_v <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_flush <= 1'b0;
          if (r_pc == HALT_PC) begin
            // Halt takes precedence over any redirect or stall this cycle.
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_redirect && !stall_i) begin
            r_pc    <= w_redir_tgt;
            r_flush <= 1'b1;
          end else if (w_redirect) begin
            r_pend_v   <= 1'b1;
            r_pend_tgt <= w_redir_tgt;
            r_state    <= ST_STALL;
          end else if (stall_i) begin
            r_state <= ST_STALL;
          end else begin
            r_pc <= w_seq_pc;
          end
        end
        ST_STALL: begin
          if (stall_i) begin
            r_flush <= 1'b0;
            // A younger jump must never displace an already-buffered branch.
            if (branch_i) begin
              r_pend_v   <= 1'b1;
              r_pend_tgt <= w_br_tgt;
            end else if (jump_i && !r_pend_v) begin
              r_pend_v   <= 1'b1;
              r_pend_tgt <= w_jmp_tgt;
            end
          end else begin
            r_state  <= ST_RUN;
            r_pend_v <= 1'b0;
            if (branch_i) begin
              r_pc    <= w_br_tgt;
              r_flush <= 1'b1;
            end else if (r_pend_v) begin
              r_pc    <= r_pend_tgt;
              r_flush <= 1'b1;
            end else if (jump_i) begin
              r_pc    <= w_jmp_tgt;
              r_flush <= 1'b1;
            end else begin
              r_pc    <= w_seq_pc;
              r_flush <= 1'b0;
            end
          end
        end
        ST_HALT: begin
          r_flush  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o     = r_pc;
  assign flush_o  = r_flush;
  assign halted_o = r_halted;
  assign state_o  = r_state;

`ifdef PC_SEQ_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic [15:0] r_stall_cnt;
  logic [15:0] r_redirect_cnt;

  // Stage p0: performance counters
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_stall_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (stall_i && (r_state != ST_HALT)) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (r_flush)                         r_redirect_cnt <= sat_inc(r_redirect_cnt);
    end
  end

  assign stall_cnt_o    = r_stall_cnt;
  assign redirect_cnt_o = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        start_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic [31:0] pc_o;
  logic        flush_o;
  logic        halted_o;
  logic [1:0]  state_o;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] redirect_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk_i           (clk_i),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .pc_o            (pc_o),
    .flush_o         (flush_o),
    .halted_o        (halted_o),
    .state_o         (state_o)
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    .stall_cnt_o     (stall_cnt_o),
    .redirect_cnt_o  (redirect_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic fl,
                         input logic hl, input logic [1:0] st);
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, fl});
    chk({tag, ".halted"}, {31'd0, halted_o}, {31'd0, hl});
    chk({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
  endtask

  initial begin
    start_i = 1'b0; stall_i = 1'b0;
    branch_i = 1'b0; branch_target_i = '0;
    jump_i = 1'b0; jump_target_i = '0;

    // 1. reset then sequential fetch
    tick(); tick();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 2'b00);
`ifdef PC_SEQ_PERF_CNT_EN
    chk("reset.stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
    chk("reset.redir_cnt", {16'd0, redirect_cnt_o}, 32'd0);
`endif
    start_i = 1'b1;
    tick(); chk_all("seq1", 32'h4, 1'b0, 1'b0, 2'b00);
    tick(); chk_all("seq2", 32'h8, 1'b0, 1'b0, 2'b00);
    tick(); chk_all("seq3", 32'hC, 1'b0, 1'b0, 2'b00);
    tick(); chk_all("seq4", 32'h10, 1'b0, 1'b0, 2'b00);

    // 2. branch without stall
    branch_i = 1'b1; branch_target_i = 32'h40;
    tick(); chk_all("br", 32'h40, 1'b1, 1'b0, 2'b00);
    branch_i = 1'b0;
    tick(); chk_all("br_after", 32'h44, 1'b0, 1'b0, 2'b00);

    // 3. priority and alignment (two back-to-back redirects)
    branch_i = 1'b1; branch_target_i = 32'h80; jump_i = 1'b1; jump_target_i = 32'hC0;
    tick(); chk_all("prio", 32'h80, 1'b1, 1'b0, 2'b00);
    jump_i = 1'b0; branch_target_i = 32'h83;
    tick(); chk_all("align", 32'h80, 1'b1, 1'b0, 2'b00);
    branch_i = 1'b0;
    tick(); chk_all("align_after", 32'h84, 1'b0, 1'b0, 2'b00);

    // 4a. jump arriving with the stall is buffered and taken on release
    stall_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h100;
    tick(); chk_all("stall1", 32'h84, 1'b0, 1'b0, 2'b01);
    jump_i = 1'b0;
    tick(); chk_all("stall2", 32'h84, 1'b0, 1'b0, 2'b01);
    tick(); chk_all("stall3", 32'h84, 1'b0, 1'b0, 2'b01);
    stall_i = 1'b0;
    tick(); chk_all("release_j", 32'h100, 1'b1, 1'b0, 2'b00);
    tick(); chk_all("release_j_after", 32'h104, 1'b0, 1'b0, 2'b00);

    // 4b. buffered branch is not displaced by a later jump
    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h200;
    tick(); chk_all("bstall1", 32'h104, 1'b0, 1'b0, 2'b01);
    branch_i = 1'b0; jump_i = 1'b1; jump_target_i = 32'h300;
    tick(); chk_all("bstall2", 32'h104, 1'b0, 1'b0, 2'b01);
    jump_i = 1'b0;
    tick(); chk_all("bstall3", 32'h104, 1'b0, 1'b0, 2'b01);
    stall_i = 1'b0;
    tick(); chk_all("release_b", 32'h200, 1'b1, 1'b0, 2'b00);
    tick(); chk_all("release_b_after", 32'h204, 1'b0, 1'b0, 2'b00);

    // 4c. a branch on the release edge beats the buffered jump
    stall_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h120;
    tick(); chk_all("cstall", 32'h204, 1'b0, 1'b0, 2'b01);
    stall_i = 1'b0; jump_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h180;
    tick(); chk_all("release_new_br", 32'h180, 1'b1, 1'b0, 2'b00);
    branch_i = 1'b0;
    tick(); chk_all("release_new_br_after", 32'h184, 1'b0, 1'b0, 2'b00);

    // 4d. plain stall releases to the sequential PC without flush
    stall_i = 1'b1;
    tick(); chk_all("pstall", 32'h184, 1'b0, 1'b0, 2'b01);
    stall_i = 1'b0;
    tick(); chk_all("prelease", 32'h188, 1'b0, 1'b0, 2'b00);

    // 5. run into HALT_PC and stay parked
    branch_i = 1'b1; branch_target_i = 32'hF0;
    tick(); chk_all("to_f0", 32'hF0, 1'b1, 1'b0, 2'b00);
    branch_i = 1'b0;
    tick(); chk_all("f4", 32'hF4, 1'b0, 1'b0, 2'b00);
    tick(); chk_all("f8", 32'hF8, 1'b0, 1'b0, 2'b00);
    branch_i = 1'b1; branch_target_i = 32'h40; stall_i = 1'b1;
    tick(); chk_all("halt_enter", 32'hF8, 1'b0, 1'b1, 2'b10);
    tick(); chk_all("halt_hold1", 32'hF8, 1'b0, 1'b1, 2'b10);
    stall_i = 1'b0; jump_i = 1'b1; jump_target_i = 32'h10;
    tick(); chk_all("halt_hold2", 32'hF8, 1'b0, 1'b1, 2'b10);
    branch_i = 1'b0; jump_i = 1'b0;

    // 6. reset mid-stall discards the buffered jump
    start_i = 1'b0;
    tick(); chk_all("rst_halt", 32'h0, 1'b0, 1'b0, 2'b00);
    start_i = 1'b1;
    tick(); chk_all("rst_run", 32'h4, 1'b0, 1'b0, 2'b00);
    stall_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h100;
    tick(); chk_all("rst_stall", 32'h4, 1'b0, 1'b0, 2'b01);
    jump_i = 1'b0; start_i = 1'b0;
    tick(); chk_all("rst_mid", 32'h0, 1'b0, 1'b0, 2'b00);
`ifdef PC_SEQ_PERF_CNT_EN
    chk("rst_mid.stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
    chk("rst_mid.redir_cnt", {16'd0, redirect_cnt_o}, 32'd0);
`endif
    start_i = 1'b1; stall_i = 1'b0;
    tick(); chk_all("post_rst1", 32'h4, 1'b0, 1'b0, 2'b00);
    tick(); chk_all("post_rst2", 32'h8, 1'b0, 1'b0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
